updown_count_monitor: RTL
=========================

# updown_count_monitor

Passive checker on the receiving end of the up/down counter's `count` bus. Samples `count` whenever the counter is enabled and reconstructs the counter's direction, turnaround events and sweep history. Flags any step that violates the legal up/down sequence. Sits beside the counter in the top level and feeds status/debug logic; it never drives the counter.

## Interface

Parameters:
- `MAX`, 15: top of the count range. 5-bit value, must be ≥ 2. Must match the counter's `max`.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  reset, synchronous and active-low; sampled on posedge `clk`.
- `enable`  in  1  counter enable; a sample is taken on each posedge with `enable`=1.
- `count`  in  5  counter value, stable at posedge.
- `dir`  out  1  inferred direction: 0 = up, 1 = down.
- `locked`  out  1  1 while tracking a legal sequence (state UP or DOWN).
- `turn`  out  1  one-cycle pulse on a legal turnaround (MAX→MAX-1 or 0→1).
- `step_err`  out  1  one-cycle pulse on an illegal sample.
- `sweeps`  out  8  count of legal turnarounds since reset; wraps 255→0.
- `errs`  out  8  count of illegal samples since reset; saturates at 255.

## Operation

- Internal register `prev[4:0]` holds the last sampled value. Arithmetic is in 6 bits, so `prev+1` and `prev-1` never alias.
- States: SYNC (no sample yet), ACQ (one reference sample, direction unknown), UP, DOWN.
- A sample is "out of range" if `count` > `MAX`. An out-of-range sample is always illegal.
- A posedge with `enable`=0 is a hold: state, `prev` and counters are unchanged, and `turn`/`step_err` are 0.
- Each sample loads `count` into `prev`.
- SYNC, on sample:
  - in range → ACQ.
  - out of range → `step_err` and stay in SYNC.
- ACQ, on sample:
  - `count`==`prev`+1 → UP, `dir`=0.
  - `count`==`prev`-1 → DOWN, `dir`=1.
  - otherwise → `step_err` and stay in ACQ.
  - No `turn` pulse is generated in ACQ.
- UP, expected next value is `prev`+1 if `prev`<`MAX`:
  - `prev`==`MAX` and `count`==`MAX`-1 → DOWN, `dir`=1, `turn`, `sweeps`+1.
  - match → stay in UP.
  - mismatch → `step_err`, `errs`+1, go to ACQ.
- DOWN, mirror of UP:
  - `prev`==0 and `count`==1 → UP, `dir`=0, `turn`, `sweeps`+1.
  - `count`==`prev`-1 → stay in DOWN.
  - mismatch → `step_err`, `errs`+1, go to ACQ.
- Every `step_err` pulse increments `errs` (saturating), including those from SYNC and ACQ.
- `dir` holds its last value while in ACQ/SYNC after an error. After reset it is 0.
- `turn` and `step_err` are mutually exclusive.

## Timing

- All outputs are registered. A sample at posedge N is reflected in the outputs after edge N, i.e. visible during cycle N+1 (1-cycle latency).
- `turn` and `step_err` are high for exactly one cycle per qualifying sample. Back-to-back qualifying samples produce back-to-back pulses.
- Reset (`reset`=0 at a posedge) overrides `enable` and any pending event. After that edge:
  - state = SYNC, `prev`=0
  - `dir`=0, `locked`=0, `turn`=0, `step_err`=0, `sweeps`=0, `errs`=0.
- Reset mid-sweep discards history. The first sample after release only re-establishes `prev`. `locked` rises one cycle after the second consecutive legal sample.
- `locked` is 0 in SYNC/ACQ and 1 in UP/DOWN. It drops in the same cycle that `step_err` pulses.
- Reaching state UP requires a minimum of 2 samples after reset.

## Test plan

- Reset, then sample 0,1,2…15,14:
  - `locked`=1 after sample 1.
  - `turn` pulses once, after 14.
  - `dir`=1 and `sweeps`=1.
  - `errs`=0.
- Continue from the previous scenario with 13…0,1:
  - a second `turn` pulse, after 1.
  - `dir`=0 and `sweeps`=2.
- While locked UP at 5, drive `enable`=0 for 5 cycles with `count` toggling 9/3:
  - no output changes.
  - on re-enable, sample 6 is accepted with no error.
- Locked UP, then sample 3 followed by 5:
  - `step_err` pulses one cycle after 5 is sampled; `locked`=0, `errs`=1.
  - samples 6,7 then give `locked`=1 with `dir`=0.
- Sample `count`=20 in each of SYNC, ACQ and UP:
  - `step_err` pulses each time and `errs`=3.
  - drive 260 illegal samples → `errs` holds at 255.
- Mid-sweep (UP at 9, `sweeps`=3), hold `reset`=0 for one cycle with `enable`=1:
  - all outputs are 0 next cycle.
  - samples 10,11 then re-lock with `sweeps`=0.

Source files
------------

// File: rtl/updown_count_monitor.sv
// Passive checker for an up/down counter's count bus: infers direction and
// turnarounds, flags illegal steps, and keeps sweep/error tallies.
module updown_count_monitor #(
  parameter logic [4:0] MAX = 5'd15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [4:0] count,
  output logic       dir,
  output logic       locked,
  output logic       turn,
  output logic       step_err,
  output logic [7:0] sweeps,
  output logic [7:0] errs
);

  typedef enum logic [1:0] {SYNC, ACQ, UP, DOWN} state_t;

  state_t     state;
  state_t     next_state;
  logic [4:0] prev;
  logic [5:0] prev_inc;
  logic [5:0] prev_dec;
  logic [5:0] count_w;
  logic       out_of_range;
  logic       next_dir;
  logic       is_turn;
  logic       is_err;

  // Six-bit neighbours so that prev-1 at zero cannot alias onto a legal value.
  assign prev_inc     = {1'b0, prev} + 6'd1;
  assign prev_dec     = {1'b0, prev} - 6'd1;
  assign count_w      = {1'b0, count};
  assign out_of_range = (count > MAX);

  always_comb begin
    next_state = state;
    next_dir   = dir;
    is_turn    = 1'b0;
    is_err     = 1'b0;
    case (state)
      SYNC: begin
        if (out_of_range) is_err = 1'b1;
        else              next_state = ACQ;
      end
      ACQ: begin
        if (!out_of_range && count_w == prev_inc) begin
          next_state = UP;
          next_dir   = 1'b0;
        end else if (!out_of_range && count_w == prev_dec) begin
          next_state = DOWN;
          next_dir   = 1'b1;
        end else begin
          is_err = 1'b1;
        end
      end
      UP: begin
        if (prev == MAX && count == MAX - 5'd1) begin
          next_state = DOWN;
          next_dir   = 1'b1;
          is_turn    = 1'b1;
        end else if (!out_of_range && prev < MAX && count_w == prev_inc) begin
          next_state = UP;
        end else begin
          next_state = ACQ;
          is_err     = 1'b1;
        end
      end
      DOWN: begin
        if (prev == 5'd0 && count == 5'd1) begin
          next_state = UP;
          next_dir   = 1'b0;
          is_turn    = 1'b1;
        end else if (!out_of_range && count_w == prev_dec) begin
          next_state = DOWN;
        end else begin
          next_state = ACQ;
          is_err     = 1'b1;
        end
      end
      default: next_state = SYNC;
    endcase
  end

  // Reset wins over enable; a disabled edge only clears the event pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= SYNC;
      prev     <= 5'd0;
      dir      <= 1'b0;
      locked   <= 1'b0;
      turn     <= 1'b0;
      step_err <= 1'b0;
      sweeps   <= 8'd0;
      errs     <= 8'd0;
    end else if (enable) begin
      state    <= next_state;
      prev     <= count;
      dir      <= next_dir;
      locked   <= (next_state == UP) || (next_state == DOWN);
      turn     <= is_turn;
      step_err <= is_err;
      if (is_turn) sweeps <= sweeps + 8'd1;
      if (is_err && errs != 8'hFF) errs <= errs + 8'd1;
    end else begin
      turn     <= 1'b0;
      step_err <= 1'b0;
    end
  end

endmodule
